prefix_encoder: RTL
===================

PREFIX_ENCODER -- requirements
Module: prefix_encoder

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port `req_valid`, input, 1 bit: a prefix request is present.
REQ-004 SHALL have port `req_ready`, output, 1 bit: the encoder accepts a request this cycle.
REQ-005 SHALL have port `req_grp1`, input, 2 bits: group-1 prefix; 00 none, 01 F0, 10 F2, 11 F3.
REQ-006 SHALL have port `req_seg`, input, 3 bits: segment prefix; 0 none, 1 26, 2 2E, 3 36, 4 3E, 5 64, 6 65, 7 reserved.
REQ-007 SHALL have port `req_opsize`, input, 1 bit: emit the 66 operand-size prefix.
REQ-008 SHALL have port `byte_valid`, output, 1 bit: `byte_data` holds a prefix byte.
REQ-009 SHALL have port `byte_ready`, input, 1 bit: the downstream consumer takes the byte.
REQ-010 SHALL have port `byte_data`, output, 8 bits: the prefix byte.
REQ-011 SHALL have port `byte_last`, output, 1 bit: the current byte is the final prefix of the request.
REQ-012 SHALL have port `s1s0`, output, 2 bits: prefix count (0-3) of the accepted request.
REQ-013 SHALL have port `size_prefix`, output, 1 bit: the accepted request contains 66.
REQ-014 SHALL have port `done`, output, 1 bit: one-cycle pulse marking request completion.

Function
REQ-015 SHALL implement FSM states IDLE, G1, SEG, OPS, DONE.
REQ-016 SHALL drive `req_ready`=1 only in IDLE; acceptance is `req_valid`&`req_ready` at a rising edge.
REQ-017 SHALL, on acceptance, register the request fields, and SHALL set `s1s0` to the count of non-none fields and `size_prefix`=`req_opsize`; both hold until the next acceptance.
REQ-018 SHALL treat `req_seg`=7 as none: no byte emitted, not counted.
REQ-019 SHALL emit bytes in the fixed order group-1, segment, 66, skipping absent fields.
REQ-020 SHALL, on acceptance, go to the first present field's state; if the request has zero fields, go directly to DONE.
REQ-021 SHALL give first-byte latency of exactly 1 cycle: `byte_valid`=1 in the cycle after acceptance.
REQ-022 SHALL assert `byte_valid` in G1, SEG and OPS, holding `byte_data` and `byte_last` stable until `byte_valid`&`byte_ready`.
REQ-023 SHALL, on a byte handshake, advance to the next present field, or to DONE if `byte_last`=1; there is no idle cycle between bytes.
REQ-024 SHALL hold `done`=1 for exactly one cycle in DONE, then return to IDLE; the next request is accepted no earlier than the cycle after DONE.
REQ-025 SHALL permit a `byte_ready` held low indefinitely, with the state and outputs frozen.
REQ-026 SHALL ignore `req_*` inputs outside IDLE.
REQ-027 SHALL keep throughput at N+2 cycles per request of N prefixes when `byte_ready`=1.

Reset
REQ-028 SHALL, while `reset`=1, asynchronously force IDLE with `req_ready`=1 and `byte_valid`, `byte_last`, `done`, `s1s0`, `size_prefix` and `byte_data` all 0.
REQ-029 SHALL discard a request in flight when reset occurs mid-emission; no further bytes of it are emitted.
REQ-030 SHALL accept a request on the first rising edge after `reset` deasserts.

Configuration
REQ-031 SHALL, with `PREFIX_ENC_PACK_EN` defined, add output `prefix_word[23:0]`: emitted bytes packed first-in-[23:16], unused low bytes 00, updated at acceptance.
REQ-032 SHALL, without `PREFIX_ENC_PACK_EN` defined, omit the `prefix_word` port and its logic entirely; all other behaviour is identical.

Verification
REQ-033 SHALL verify: grp1=11, seg=5, opsize=1, `byte_ready`=1 -> bytes F3, 64, 66 on consecutive cycles, `byte_last` on 66, `s1s0`=3, `size_prefix`=1, `done` 1 cycle later; `prefix_word`=F36466 when `PREFIX_ENC_PACK_EN` is defined.
REQ-034 SHALL verify: all fields none -> no `byte_valid`, `done` 1 cycle after acceptance, `s1s0`=0, `prefix_word`=000000.
REQ-035 SHALL verify: seg=2 only with `byte_ready` low 4 cycles -> `byte_data`=2E held stable 5 cycles, `byte_last`=1, `s1s0`=1.
REQ-036 SHALL verify: seg=7, opsize=1 -> single byte 66, `s1s0`=1, `size_prefix`=1.
REQ-037 SHALL verify: reset pulsed after the first byte of F0,26,66 -> `byte_valid` drops immediately, no further bytes, `req_ready`=1, outputs 0.
REQ-038 SHALL verify: `req_valid` held high for back-to-back requests -> second acceptance is exactly 1 cycle after `done`, with no byte lost or duplicated.

Source files
------------

// File: rtl/prefix_encoder.sv
// Streams the group-1, segment and 66 prefix bytes of an accepted request, skipping absent fields.
// Define PREFIX_ENC_PACK_EN to add the packed prefix_word[23:0] output.
module prefix_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_grp1,
    input  logic [2:0]  req_seg,
    input  logic        req_opsize,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    output logic [1:0]  s1s0,
    output logic        size_prefix,
`ifdef PREFIX_ENC_PACK_EN
    output logic [23:0] prefix_word,
`endif
    output logic        done
);

    typedef enum logic [2:0] {StIdle, StG1, StSeg, StOps, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grp1_q, grp1_d;
    logic [2:0]  seg_q, seg_d;
    logic        ops_q, ops_d;
    logic [1:0]  s1s0_q, s1s0_d;
    logic        size_prefix_q, size_prefix_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_last_q, byte_last_d;
    logic        done_q, done_d;

    // Segment code 7 is reserved and treated exactly like "none".
    function automatic logic seg_present(input logic [2:0] s);
        return (s != 3'd0) && (s != 3'd7);
    endfunction

    function automatic state_e next_field(input state_e cur, input logic [1:0] g,
                                          input logic [2:0] s, input logic o);
        state_e nxt;
        nxt = StDone;
        if (o && (cur == StIdle || cur == StG1 || cur == StSeg)) nxt = StOps;
        if (seg_present(s) && (cur == StIdle || cur == StG1)) nxt = StSeg;
        if ((g != 2'd0) && (cur == StIdle)) nxt = StG1;
        return nxt;
    endfunction

    function automatic logic [7:0] field_byte(input state_e st, input logic [1:0] g,
                                              input logic [2:0] s);
        logic [7:0] b;
        b = 8'h00;
        if (st == StG1) begin
            case (g)
                2'd1:    b = 8'hf0;
                2'd2:    b = 8'hf2;
                2'd3:    b = 8'hf3;
                default: b = 8'h00;
            endcase
        end else if (st == StSeg) begin
            case (s)
                3'd1:    b = 8'h26;
                3'd2:    b = 8'h2e;
                3'd3:    b = 8'h36;
                3'd4:    b = 8'h3e;
                3'd5:    b = 8'h64;
                3'd6:    b = 8'h65;
                default: b = 8'h00;
            endcase
        end else if (st == StOps) begin
            b = 8'h66;
        end
        return b;
    endfunction

    always_comb begin
        state_d       = state_q;
        grp1_d        = grp1_q;
        seg_d         = seg_q;
        ops_d         = ops_q;
        s1s0_d        = s1s0_q;
        size_prefix_d = size_prefix_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    grp1_d        = req_grp1;
                    seg_d         = req_seg;
                    ops_d         = req_opsize;
                    s1s0_d        = {1'b0, req_grp1 != 2'd0} + {1'b0, seg_present(req_seg)}
                                    + {1'b0, req_opsize};
                    size_prefix_d = req_opsize;
                    state_d       = next_field(StIdle, req_grp1, req_seg, req_opsize);
                end
            end
            StG1, StSeg, StOps: begin
                if (byte_ready) state_d = next_field(state_q, grp1_q, seg_q, ops_q);
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        byte_valid_d = (state_d == StG1) || (state_d == StSeg) || (state_d == StOps);
        byte_data_d  = field_byte(state_d, grp1_d, seg_d);
        byte_last_d  = byte_valid_d && (next_field(state_d, grp1_d, seg_d, ops_d) == StDone);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            grp1_q        <= 2'd0;
            seg_q         <= 3'd0;
            ops_q         <= 1'b0;
            s1s0_q        <= 2'd0;
            size_prefix_q <= 1'b0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= 8'h00;
            byte_last_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grp1_q        <= grp1_d;
            seg_q         <= seg_d;
            ops_q         <= ops_d;
            s1s0_q        <= s1s0_d;
            size_prefix_q <= size_prefix_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            byte_last_q   <= byte_last_d;
            done_q        <= done_d;
        end
    end

`ifdef PREFIX_ENC_PACK_EN
    logic [23:0] prefix_word_q, prefix_word_d;

    always_comb begin
        logic [23:0] w;
        w = 24'h0;
        if (req_grp1 != 2'd0) w = {w[15:0], field_byte(StG1, req_grp1, req_seg)};
        if (seg_present(req_seg)) w = {w[15:0], field_byte(StSeg, req_grp1, req_seg)};
        if (req_opsize) w = {w[15:0], 8'h66};
        // Left-justify so the first emitted byte lands in [23:16].
        case (s1s0_d)
            2'd1:    w = {w[7:0], 16'h0};
            2'd2:    w = {w[15:0], 8'h0};
            default: ;
        endcase
        prefix_word_d = prefix_word_q;
        if (state_q == StIdle && req_valid) prefix_word_d = w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prefix_word_q <= 24'h0;
        else       prefix_word_q <= prefix_word_d;
    end

    assign prefix_word = prefix_word_q;
`endif

    assign req_ready   = (state_q == StIdle);
    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_last   = byte_last_q;
    assign s1s0        = s1s0_q;
    assign size_prefix = size_prefix_q;
    assign done        = done_q;

endmodule
